// File: rtl/mult_div_unit.sv
// rtl/mult_div_unit.sv - iterative 32-bit multiply/divide unit with HI/LO registers
module mult_div_unit (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] operand_a,
  input  logic [31:0] operand_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_MUL  = 2'd1;
  localparam logic [1:0] S_DIV  = 2'd2;

  localparam logic [2:0] OP_MULT  = 3'b000;
  localparam logic [2:0] OP_MULTU = 3'b001;
  localparam logic [2:0] OP_DIV   = 3'b010;
  localparam logic [2:0] OP_DIVU  = 3'b011;
  localparam logic [2:0] OP_MTHI  = 3'b100;
  localparam logic [2:0] OP_MTLO  = 3'b101;

  logic [1:0]  r_state;
  logic [5:0]  r_cnt;
  logic [63:0] r_acc;
  logic [31:0] r_b;
  logic        r_neg_q;
  logic        r_neg_r;
  logic        r_done;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic        w_signed;
  logic [31:0] w_a_mag;
  logic [31:0] w_b_mag;
  logic [32:0] w_mul_sum;
  logic [63:0] w_mul_next;
  logic [63:0] w_prod;
  logic [32:0] w_div_shift;
  logic [32:0] w_div_diff;
  logic        w_div_ge;
  logic [63:0] w_div_next;
  logic [31:0] w_div_q;
  logic [31:0] w_div_r;
  logic [31:0] w_quot;
  logic [31:0] w_rem;

  assign w_signed = (op == OP_MULT) || (op == OP_DIV);
  assign w_a_mag  = (w_signed && operand_a[31]) ? (~operand_a + 32'd1) : operand_a;
  assign w_b_mag  = (w_signed && operand_b[31]) ? (~operand_b + 32'd1) : operand_b;

  // Multiply: r_acc = {partial product high, remaining multiplier bits}
  assign w_mul_sum  = {1'b0, r_acc[63:32]} + (r_acc[0] ? {1'b0, r_b} : 33'd0);
  assign w_mul_next = {w_mul_sum, r_acc[31:1]};
  assign w_prod     = r_neg_q ? (~w_mul_next + 64'd1) : w_mul_next;

  // Divide: r_acc = {partial remainder, dividend bits shifting into quotient}
  assign w_div_shift = r_acc[63:31];
  assign w_div_diff  = w_div_shift - {1'b0, r_b};
  assign w_div_ge    = (w_div_shift >= {1'b0, r_b});
  assign w_div_next  = w_div_ge ? {w_div_diff[31:0], r_acc[30:0], 1'b1}
                                : {w_div_shift[31:0], r_acc[30:0], 1'b0};
  assign w_div_q     = w_div_next[31:0];
  assign w_div_r     = w_div_next[63:32];
  // A zero divisor leaves the all-ones quotient unsigned regardless of operand signs
  assign w_quot      = (r_neg_q && (r_b != 32'd0)) ? (~w_div_q + 32'd1) : w_div_q;
  assign w_rem       = r_neg_r ? (~w_div_r + 32'd1) : w_div_r;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
      r_cnt   <= 6'd0;
      r_acc   <= 64'd0;
      r_b     <= 32'd0;
      r_neg_q <= 1'b0;
      r_neg_r <= 1'b0;
      r_done  <= 1'b0;
      r_hi    <= 32'd0;
      r_lo    <= 32'd0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            case (op)
              OP_MULT, OP_MULTU, OP_DIV, OP_DIVU: begin
                r_state <= op[1] ? S_DIV : S_MUL;
                r_cnt   <= 6'd0;
                r_acc   <= {32'd0, w_a_mag};
                r_b     <= w_b_mag;
                r_neg_q <= w_signed && (operand_a[31] ^ operand_b[31]);
                r_neg_r <= w_signed && operand_a[31];
              end
              OP_MTHI: r_hi <= operand_a;
              OP_MTLO: r_lo <= operand_a;
              default: ;
            endcase
          end
        end
        S_MUL: begin
          r_acc <= w_mul_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_hi    <= w_prod[63:32];
            r_lo    <= w_prod[31:0];
            r_cnt   <= 6'd0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        S_DIV: begin
          r_acc <= w_div_next;
          r_cnt <= r_cnt + 6'd1;
          if (r_cnt == 6'd31) begin
            r_hi    <= w_rem;
            r_lo    <= w_quot;
            r_cnt   <= 6'd0;
            r_state <= S_IDLE;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy = (r_state != S_IDLE);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;

endmodule

// File: doc/mult_div_unit.md
MULT_DIV_UNIT -- requirements
Module: mult_div_unit

Interface
REQ-001 SHALL have no parameters; all datapaths fixed at 32 bits.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset; one clock, reset is synchronous and active-high.
REQ-004 start  input  1  request; sampled on rising edge of clk.
REQ-005 op  input  3  operation: 000 MULT, 001 MULTU, 010 DIV, 011 DIVU, 100 MTHI, 101 MTLO; 110/111 reserved.
REQ-006 operand_a  input  32  rs value, register-file read port 1; dividend for DIV/DIVU.
REQ-007 operand_b  input  32  rt value, register-file read port 2; divisor for DIV/DIVU.
REQ-008 busy  output  1  high while an iterative operation is in progress.
REQ-009 done  output  1  single-cycle pulse when MULT/MULTU/DIV/DIVU results land in hi/lo.
REQ-010 hi  output  32  HI register: product upper word or remainder.
REQ-011 lo  output  32  LO register: product lower word or quotient.

Function
REQ-012 SHALL implement a state machine with states IDLE, MUL, DIV; only IDLE accepts requests.
REQ-013 Acceptance: start=1 and busy=0 at rising edge E0; requests with busy=1 SHALL be ignored with no state change.
REQ-014 Reserved op codes SHALL be ignored: no state change, no done.
REQ-015 MTHI/MTLO SHALL write operand_a into hi/lo at E0; busy stays 0; done not asserted; the other register is unchanged.
REQ-016 MULT/MULTU/DIV/DIVU SHALL capture operands at E0, enter MUL or DIV, and drive busy=1 from E0 until E32.
REQ-017 Operand changes after E0 SHALL NOT affect the result.
REQ-018 SHALL perform one shift-add (MUL) or restoring shift-subtract (DIV) step per cycle on edges E1..E32, using a 6-bit iteration counter.
REQ-019 At E32 SHALL write hi/lo, return to IDLE, set busy=0 and done=1 for exactly one cycle.
REQ-020 hi/lo SHALL hold their previous values during iteration; intermediate values SHALL NOT be visible.
REQ-021 A new request SHALL be accepted in the cycle done=1, giving a 33-cycle back-to-back issue interval.
REQ-022 Signed ops SHALL convert operands to magnitudes at E0 and apply signs at E32.
REQ-023 Signed sign rules: product negated if operand signs differ; quotient negated if signs differ; remainder takes the dividend's sign.
REQ-024 MULT/MULTU SHALL produce the full 64-bit product {hi,lo}; no overflow indication.
REQ-025 Divide by zero (any divide) SHALL take the full 32 cycles and produce lo=0xFFFFFFFF, hi=operand_a as captured.
REQ-026 DIV 0x80000000 / 0xFFFFFFFF SHALL produce lo=0x80000000, hi=0x00000000 with no exception.

Reset
REQ-027 reset=1 at a rising edge SHALL force state IDLE, busy=0, done=0, hi=0, lo=0 and the counter to 0.
REQ-028 Reset SHALL take priority over start, including mid-operation; an in-flight operation is discarded with no done.
REQ-029 The first rising edge with reset=0 SHALL be able to accept a request.

Verification
REQ-030 MULTU a=0xFFFFFFFF b=0xFFFFFFFF -> busy for 32 cycles, then done pulse with hi=0xFFFFFFFE, lo=0x00000001.
REQ-031 MULT a=0xFFFFFFFD(-3) b=0x00000005 -> hi=0xFFFFFFFF, lo=0xFFFFFFF1; DIV a=0xFFFFFFF9(-7) b=0x00000002 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
REQ-032 DIVU a=0x00000007 b=0 -> done after 32 cycles, lo=0xFFFFFFFF, hi=0x00000007; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-033 While DIVU 100/7 is busy: issue MULT and MTHI 0x1234 -> both ignored; final lo=14, hi=2; hi never reads 0x1234.
REQ-034 Reset asserted at cycle 10 of a DIV -> next cycle busy=0, hi=lo=0, no done ever; MTLO 0xABCD right after reset -> lo=0xABCD next cycle.
REQ-035 Back-to-back MULTU 3*4 then MULTU 5*6 issued on the done cycle -> lo=12, then 33 cycles later lo=30, hi=0.
